tile_plotter: RTL and testbench
===============================

TILE_PLOTTER -- requirements
Module: tile_plotter

Interface
REQ-001 Parameter TILE_W, default 40, tile width in pixels; equals lane pitch.
REQ-002 Parameter TILE_H, default 30, tile height in pixels.
REQ-003 Parameter BORDER_COLOR, default 3'b000, colour of the 1-pixel tile outline.
REQ-004 CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-005 resetn  in  1  synchronous active-low reset, sampled on the CLOCK_50 rising edge.
REQ-006 start  in  1  one-cycle request to draw a tile; sampled only in IDLE.
REQ-007 clear  in  1  one-cycle request to fill the screen black; sampled only in IDLE.
REQ-008 lane  in  2  tile column, 0-3.
REQ-009 tile_y  in  7  tile top row, 0-127.
REQ-010 tile_color  in  3  fill colour of the tile interior.
REQ-011 VGA_X  out  8  pixel column, 0-159.
REQ-012 VGA_Y  out  7  pixel row, 0-119.
REQ-013 VGA_COLOR  out  3  pixel colour.
REQ-014 plot  out  1  write strobe; the pixel on VGA_X/VGA_Y/VGA_COLOR is written in every cycle plot=1.
REQ-015 busy  out  1  high in DRAW and CLEAR.
REQ-016 done  out  1  one-cycle pulse when an operation completes.

Function
REQ-017 States: IDLE, DRAW, CLEAR, DONE.
REQ-018 IDLE: clear=1 -> CLEAR; else start=1 -> DRAW; clear has priority when both are high in the same cycle.
REQ-019 On the IDLE exit edge, latch lane, tile_y and tile_color; zero col and row counters.
REQ-020 Input changes after the latch edge have no effect on the operation in progress.
REQ-021 DRAW: one pixel per cycle, raster order, col fastest; col 0..TILE_W-1, row 0..TILE_H-1.
REQ-022 DRAW pixel coordinates: VGA_X = lane*TILE_W + col (8-bit); VGA_Y = tile_y + row, computed 8 bits wide.
REQ-023 DRAW pixel colour: BORDER_COLOR where col=0, col=TILE_W-1, row=0 or row=TILE_H-1; else latched tile_color.
REQ-024 Clipping: when tile_y + row >= 120 (8-bit sum), plot=0 for that pixel, counters still advance, and VGA_Y shows the low 7 bits of the sum.
REQ-025 DRAW lasts exactly TILE_W*TILE_H cycles, then -> DONE.
REQ-026 CLEAR: x 0..159 fastest, y 0..119; VGA_COLOR=3'b000; plot=1 every cycle.
REQ-027 CLEAR lasts exactly 19200 cycles, then -> DONE.
REQ-028 DONE: done=1, plot=0, busy=0 for one cycle, then -> IDLE.
REQ-029 start or clear asserted outside IDLE is ignored, not queued.
REQ-030 Outputs are registered; the first pixel appears in the cycle after the latch edge.
REQ-031 In IDLE and DONE, plot=0 and VGA_X/VGA_Y/VGA_COLOR hold their last values.

Reset
REQ-032 resetn=0 on any edge forces: IDLE, VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0, busy=0, done=0, counters 0.
REQ-033 Reset mid-DRAW or mid-CLEAR aborts the operation with no done pulse; after release, the next start or clear begins from pixel 0.

Verification
REQ-034 start, lane=2, tile_y=10, tile_color=3'b100 -> 1200 consecutive plot cycles: first pixel (80,10) colour 000, pixel (81,11) colour 100, last pixel (119,39); done one cycle later.
REQ-035 start, lane=0, tile_y=100 -> 1200 busy cycles; plot=1 only for rows 100-119 (800 pixels); done at the same cycle offset as an unclipped draw.
REQ-036 clear and start high in the same cycle -> CLEAR runs: 19200 plot cycles at colour 000, last pixel (159,119), then done.
REQ-037 start pulsed during DRAW -> ignored; exactly one done; pixel count unchanged.
REQ-038 resetn=0 held for 1 cycle mid-CLEAR -> next edge: plot=0, busy=0, VGA_X=0, VGA_Y=0, no done; a following start draws a full tile.
REQ-039 Scoreboard: count plot cycles and compare each (VGA_X, VGA_Y, VGA_COLOR) against a reference raster model for random lane, tile_y and colour.

Source files
------------

// File: rtl/tile_plotter_if.sv
// Request and pixel-stream bundle for tile_plotter. The requester drives the
// master side. The plotter drives the slave side and writes one pixel per plot strobe.
interface tile_plotter_if;
  logic       start;
  logic       clear;
  logic [1:0] lane;
  logic [6:0] tile_y;
  logic [2:0] tile_color;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, clear, lane, tile_y, tile_color,
    input  VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
  );

  modport slave (
    input  start, clear, lane, tile_y, tile_color,
    output VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
  );
endinterface

// File: rtl/tile_plotter.sv
// Rasterises one outlined tile, or blanks the 160x120 screen, at one pixel per clock.
// Every pixel output is registered, so the first pixel is already valid in the first busy cycle.
module tile_plotter #(
  parameter int         TILE_W       = 40,
  parameter int         TILE_H       = 30,
  parameter logic [2:0] BORDER_COLOR = 3'b000
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  tile_plotter_if.slave  bus
);
  localparam logic [7:0] LANE_PITCH = 8'(TILE_W);
  localparam logic [7:0] COL_LAST   = 8'(TILE_W - 1);
  localparam logic [6:0] ROW_LAST   = 7'(TILE_H - 1);
  localparam logic [7:0] SCR_X_LAST = 8'd159;
  localparam logic [6:0] SCR_Y_LAST = 7'd119;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CLEAR, S_DONE} state_t;

  state_t     state_reg, state_next;
  logic [1:0] lane_reg, lane_next;
  logic [6:0] tile_y_reg, tile_y_next;
  logic [2:0] color_reg, color_next;
  logic [7:0] col_reg, col_next;
  logic [6:0] row_reg, row_next;
  logic [7:0] x_reg, x_next;
  logic [6:0] y_reg, y_next;
  logic [2:0] vga_color_reg, vga_color_next;
  logic       plot_reg, plot_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;

  logic [1:0] src_lane;
  logic [6:0] src_y;
  logic [2:0] src_color;
  logic [7:0] pix_col, draw_x, sum_y, clr_x;
  logic [6:0] pix_row, clr_y;
  logic [2:0] draw_color;
  logic       draw_vis, draw_wrap, draw_last, clr_wrap, clr_last;

  assign draw_wrap = (col_reg == COL_LAST);
  assign draw_last = draw_wrap && (row_reg == ROW_LAST);
  assign clr_wrap  = (col_reg == SCR_X_LAST);
  assign clr_last  = clr_wrap && (row_reg == SCR_Y_LAST);
  assign clr_x     = clr_wrap ? 8'd0 : col_reg + 8'd1;
  assign clr_y     = clr_wrap ? row_reg + 7'd1 : row_reg;

  // Pixel that will be shown next: on the launch edge it comes straight from the inputs.
  always_comb begin
    src_lane  = lane_reg;
    src_y     = tile_y_reg;
    src_color = color_reg;
    pix_col   = draw_wrap ? 8'd0 : col_reg + 8'd1;
    pix_row   = draw_wrap ? row_reg + 7'd1 : row_reg;
    if (state_reg == S_IDLE) begin
      src_lane  = bus.lane;
      src_y     = bus.tile_y;
      src_color = bus.tile_color;
      pix_col   = 8'd0;
      pix_row   = 7'd0;
    end
    draw_x     = {6'd0, src_lane} * LANE_PITCH + pix_col;
    sum_y      = {1'b0, src_y} + {1'b0, pix_row};
    draw_vis   = (sum_y < 8'd120);
    draw_color = (pix_col == 8'd0 || pix_col == COL_LAST ||
                  pix_row == 7'd0 || pix_row == ROW_LAST) ? BORDER_COLOR : src_color;
  end

  always_comb begin
    state_next     = state_reg;
    lane_next      = lane_reg;
    tile_y_next    = tile_y_reg;
    color_next     = color_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    vga_color_next = vga_color_reg;
    plot_next      = 1'b0;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.clear) begin
          state_next     = S_CLEAR;
          col_next       = 8'd0;
          row_next       = 7'd0;
          x_next         = 8'd0;
          y_next         = 7'd0;
          vga_color_next = 3'b000;
          plot_next      = 1'b1;
          busy_next      = 1'b1;
        end else if (bus.start) begin
          state_next     = S_DRAW;
          lane_next      = bus.lane;
          tile_y_next    = bus.tile_y;
          color_next     = bus.tile_color;
          col_next       = pix_col;
          row_next       = pix_row;
          x_next         = draw_x;
          y_next         = sum_y[6:0];
          vga_color_next = draw_color;
          plot_next      = draw_vis;
          busy_next      = 1'b1;
        end
      end
      S_DRAW: begin
        if (draw_last) begin
          state_next = S_DONE;
          col_next   = 8'd0;
          row_next   = 7'd0;
          done_next  = 1'b1;
        end else begin
          col_next       = pix_col;
          row_next       = pix_row;
          x_next         = draw_x;
          y_next         = sum_y[6:0];
          vga_color_next = draw_color;
          plot_next      = draw_vis;
          busy_next      = 1'b1;
        end
      end
      S_CLEAR: begin
        if (clr_last) begin
          state_next = S_DONE;
          col_next   = 8'd0;
          row_next   = 7'd0;
          done_next  = 1'b1;
        end else begin
          col_next       = clr_x;
          row_next       = clr_y;
          x_next         = clr_x;
          y_next         = clr_y;
          vga_color_next = 3'b000;
          plot_next      = 1'b1;
          busy_next      = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      lane_reg      <= 2'd0;
      tile_y_reg    <= 7'd0;
      color_reg     <= 3'd0;
      col_reg       <= 8'd0;
      row_reg       <= 7'd0;
      x_reg         <= 8'd0;
      y_reg         <= 7'd0;
      vga_color_reg <= 3'd0;
      plot_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lane_reg      <= lane_next;
      tile_y_reg    <= tile_y_next;
      color_reg     <= color_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      vga_color_reg <= vga_color_next;
      plot_reg      <= plot_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign bus.VGA_X     = x_reg;
  assign bus.VGA_Y     = y_reg;
  assign bus.VGA_COLOR = vga_color_reg;
  assign bus.plot      = plot_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
endmodule

// File: tb/tb_tile_plotter.sv
// Directed and scoreboarded checks of tile_plotter: tile raster, clipping, clear,
// request priority, ignored requests and reset abort. One line is printed per transaction.
module tb_tile_plotter;
  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [18:0] pix_log [0:1199];

  tile_plotter_if bus ();

  tile_plotter dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Packed pixel: {plot, x[7:0], y[6:0], colour[2:0]}
  function automatic logic [18:0] observed();
    return {bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR};
  endfunction

  function automatic logic [18:0] ref_draw(input logic [1:0] ln, input logic [6:0] ty,
                                           input logic [2:0] c, input int k);
    int col, row;
    logic [7:0] x, ys;
    logic [2:0] pc;
    col = k % 40;
    row = k / 40;
    x   = 8'(int'(ln) * 40 + col);
    ys  = 8'(int'(ty) + row);
    pc  = (col == 0 || col == 39 || row == 0 || row == 29) ? 3'b000 : c;
    return {(ys < 8'd120), x, ys[6:0], pc};
  endfunction

  // Called at the falling edge inside the DONE cycle.
  task automatic check_done_tail(input string tag);
    int extra;
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_done_plot"}, 32'(bus.plot), 0);
    check({tag, "_done_busy"}, 32'(bus.busy), 0);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.plot) extra++;
    end
    check({tag, "_idle_quiet"}, 32'(extra), 0);
  endtask

  task automatic run_draw(input string tag, input logic [1:0] ln, input logic [6:0] ty,
                          input logic [2:0] c, input bit poke, output int plots);
    int bad, stray;
    logic [18:0] o;
    @(negedge clk);
    bus.start = 1'b1; bus.lane = ln; bus.tile_y = ty; bus.tile_color = c;
    @(negedge clk);
    bus.start = 1'b0; bus.lane = ~ln; bus.tile_y = ~ty; bus.tile_color = ~c;
    bad = 0; plots = 0; stray = 0;
    for (int k = 0; k < 1200; k++) begin
      o = observed();
      pix_log[k] = o;
      if (o !== ref_draw(ln, ty, c, k)) bad++;
      if (bus.plot) plots++;
      if (!bus.busy || bus.done) stray++;
      bus.start = (poke && k == 500);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_pix_bad"}, 32'(bad), 0);
    check({tag, "_busy_done_in_op"}, 32'(stray), 0);
    check_done_tail(tag);
    $display("draw %s lane=%0d y=%0d color=%0d plots=%0d", tag, ln, ty, c, plots);
  endtask

  initial begin
    int plots, bad, stray;
    logic [18:0] o, last;
    bus.start = 1'b0; bus.clear = 1'b0; bus.lane = 2'd0;
    bus.tile_y = 7'd0; bus.tile_color = 3'd0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(bus.VGA_X), 0);
    check("rst_y", 32'(bus.VGA_Y), 0);
    check("rst_color", 32'(bus.VGA_COLOR), 0);
    check("rst_plot", 32'(bus.plot), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    $display("reset outputs idle");
    resetn = 1'b1;
    @(negedge clk);

    run_draw("t_lane2", 2'd2, 7'd10, 3'b100, 1'b0, plots);
    check("t_lane2_plots", 32'(plots), 1200);
    check("t_lane2_first", 32'(pix_log[0]), {13'd0, 1'b1, 8'd80, 7'd10, 3'b000});
    check("t_lane2_px81_11", 32'(pix_log[41]), {13'd0, 1'b1, 8'd81, 7'd11, 3'b100});
    check("t_lane2_last", 32'(pix_log[1199]), {13'd0, 1'b1, 8'd119, 7'd39, 3'b000});

    run_draw("t_clip", 2'd0, 7'd100, 3'b010, 1'b0, plots);
    check("t_clip_plots", 32'(plots), 800);
    check("t_clip_row120", 32'(pix_log[800]), {13'd0, 1'b0, 8'd0, 7'd120, 3'b000});
    check("t_clip_last", 32'(pix_log[1199]), {13'd0, 1'b0, 8'd39, 7'd1, 3'b000});

    run_draw("t_poke", 2'd1, 7'd50, 3'b011, 1'b1, plots);
    check("t_poke_plots", 32'(plots), 1200);

    // clear wins over start in the same cycle
    @(negedge clk);
    bus.clear = 1'b1; bus.start = 1'b1; bus.lane = 2'd3; bus.tile_y = 7'd5; bus.tile_color = 3'b111;
    @(negedge clk);
    bus.clear = 1'b0; bus.start = 1'b0;
    bad = 0; plots = 0; stray = 0; last = '0;
    for (int k = 0; k < 19200; k++) begin
      o = observed();
      if (o !== {1'b1, 8'(k % 160), 7'(k / 160), 3'b000}) bad++;
      if (bus.plot) plots++;
      if (!bus.busy || bus.done) stray++;
      last = o;
      @(negedge clk);
    end
    check("clr_pix_bad", 32'(bad), 0);
    check("clr_plots", 32'(plots), 19200);
    check("clr_busy_done_in_op", 32'(stray), 0);
    check("clr_last", 32'(last), {13'd0, 1'b1, 8'd159, 7'd119, 3'b000});
    check_done_tail("clr");
    $display("clear with start also high plots=%0d", plots);

    // reset held one cycle in the middle of a clear
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (500) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("abort_plot", 32'(bus.plot), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_x", 32'(bus.VGA_X), 0);
    check("abort_y", 32'(bus.VGA_Y), 0);
    check("abort_done", 32'(bus.done), 0);
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray++;
    end
    check("abort_quiet", 32'(stray), 0);
    $display("reset mid-clear aborted");
    run_draw("t_after_abort", 2'd3, 7'd0, 3'b111, 1'b0, plots);
    check("t_after_abort_plots", 32'(plots), 1200);
    check("t_after_abort_first", 32'(pix_log[0]), {13'd0, 1'b1, 8'd120, 7'd0, 3'b000});

    for (int r = 0; r < 3; r++) begin
      run_draw($sformatf("t_rand%0d", r), 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
               3'($urandom_range(0, 7)), 1'b0, plots);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
